// File: rtl/trivium_out_fifo_if.sv
// Write/read/status bundle between the Trivium encryptor, the output FIFO and the consumer.
interface trivium_out_fifo_if #(
  parameter int unsigned DEPTH = 512
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       wr_data;
  logic             wr_en;
  logic             flush;
  logic [7:0]       rd_data;
  logic             rd_last;
  logic             rd_valid;
  logic             rd_ready;
  logic [1:0]       fifo_cnd;
  logic [LVL_W-1:0] level;

  // FIFO side
  modport slave (
    input  wr_data, wr_en, flush, rd_ready,
    output rd_data, rd_last, rd_valid, fifo_cnd, level
  );

  // Encryptor/consumer side
  modport master (
    output wr_data, wr_en, flush, rd_ready,
    input  rd_data, rd_last, rd_valid, fifo_cnd, level
  );
endinterface

// File: rtl/trivium_out_fifo.sv
// First-word-fall-through ciphertext buffer with per-block last tagging and
// a fill-level status code polled by the encryptor between blocks.
module trivium_out_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned BLOCK = 256
) (
  input  logic               clk,
  input  logic               rst,
  trivium_out_fifo_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned BLK_W = (BLOCK > 1) ? $clog2(BLOCK) : 1;

  localparam logic [1:0] CND_ROOM = 2'b00;
  localparam logic [1:0] CND_LOW  = 2'b01;
  localparam logic [1:0] CND_FULL = 2'b10;
  localparam logic [1:0] CND_OVF  = 2'b11;

  // Elaboration-time parameter sanity
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("trivium_out_fifo: DEPTH must be a power of two >= 2");
  end
  if ((BLOCK < 2) || ((BLOCK & (BLOCK - 1)) != 0) || (BLOCK > DEPTH)) begin : g_bad_block
    $error("trivium_out_fifo: BLOCK must be a power of two, 2 <= BLOCK <= DEPTH");
  end

  logic [8:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q,  count_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             ovf_q,    ovf_d;

  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic             tag_c;
  logic             mem_we_c;
  logic [8:0]       mem_wdata_c;
  logic [LVL_W-1:0] free_c;

  // Handshake decode; a pop frees the slot a same-cycle push needs when full
  always_comb begin
    full_c      = (count_q == LVL_W'(DEPTH));
    pop_c       = bus.rd_valid && bus.rd_ready;
    push_c      = bus.wr_en && (!full_c || pop_c);
    drop_c      = bus.wr_en && full_c && !pop_c;
    tag_c       = (blk_cnt_q == BLK_W'(BLOCK - 1));
    mem_we_c    = push_c && !bus.flush;
    mem_wdata_c = {tag_c, bus.wr_data};
  end

  // Next-state for pointers, count, block counter and overflow flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    blk_cnt_d = blk_cnt_q;
    ovf_d     = ovf_q;

    if (bus.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      blk_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
      if (drop_c) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      blk_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      blk_cnt_q <= blk_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage array is intentionally left unreset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[wr_ptr_q] <= mem_wdata_c;
    end
  end

  // Status code, highest-priority condition first
  always_comb begin
    free_c       = LVL_W'(DEPTH) - count_q;
    bus.fifo_cnd = CND_ROOM;
    if (ovf_q) begin
      bus.fifo_cnd = CND_OVF;
    end else if (full_c) begin
      bus.fifo_cnd = CND_FULL;
    end else if (free_c < LVL_W'(BLOCK)) begin
      bus.fifo_cnd = CND_LOW;
    end
  end

  assign {bus.rd_last, bus.rd_data} = mem_q[rd_ptr_q];
  assign bus.rd_valid               = (count_q != '0);
  assign bus.level                  = count_q;

endmodule

// File: tb/tb_trivium_out_fifo.sv
// Directed bench for trivium_out_fifo at DEPTH=512, BLOCK=256.
module tb_trivium_out_fifo;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned BLOCK = 256;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  logic [8:0] exp_q[$];

  trivium_out_fifo_if #(.DEPTH(DEPTH)) bus ();

  trivium_out_fifo #(.DEPTH(DEPTH), .BLOCK(BLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      bus.wr_data = 8'(start + i);
      bus.wr_en   = 1'b1;
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  // Pops until the expected queue is exhausted, checking every head byte
  task automatic drain();
    logic [8:0] e;
    bus.rd_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("drain_valid", 32'(bus.rd_valid), 32'd1);
      check("drain_data",  32'(bus.rd_data),  32'(e[7:0]));
      check("drain_last",  32'(bus.rd_last),  32'(e[8]));
      step();
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic expect_blocks(input int first, input int last_idx);
    for (int i = first; i <= last_idx; i++) begin
      exp_q.push_back({((i % 256) == 255) ? 1'b1 : 1'b0, 8'(i)});
    end
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    rst          = 1'b0;
    bus.wr_data  = 8'h00;
    bus.wr_en    = 1'b0;
    bus.flush    = 1'b0;
    bus.rd_ready = 1'b0;

    #12;
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_level", 32'(bus.level),    32'd0);
    check("rst_cnd",   32'(bus.fifo_cnd), 32'd0);
    step();
    rst = 1'b1;
    step();
    step();
    check("idle_valid", 32'(bus.rd_valid), 32'd0);
    check("idle_level", 32'(bus.level),    32'd0);
    check("idle_cnd",   32'(bus.fifo_cnd), 32'd0);

    // Fill through each status threshold, then overflow
    push_bytes(256, 0);
    check("fill256_level", 32'(bus.level),    32'd256);
    check("fill256_cnd",   32'(bus.fifo_cnd), 32'd0);
    push_bytes(1, 0);
    check("fill257_level", 32'(bus.level),    32'd257);
    check("fill257_cnd",   32'(bus.fifo_cnd), 32'd1);
    push_bytes(255, 1);
    check("full_level", 32'(bus.level),    32'd512);
    check("full_cnd",   32'(bus.fifo_cnd), 32'd2);
    push_bytes(1, 8'hAA);
    check("ovf_level", 32'(bus.level),    32'd512);
    check("ovf_cnd",   32'(bus.fifo_cnd), 32'd3);
    expect_blocks(0, 511);
    drain();
    check("ovf_drained_valid", 32'(bus.rd_valid), 32'd0);
    check("ovf_drained_level", 32'(bus.level),    32'd0);
    check("ovf_sticky_cnd",    32'(bus.fifo_cnd), 32'd3);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_cnd", 32'(bus.fifo_cnd), 32'd0);

    // Simultaneous push and pop while full
    push_bytes(512, 0);
    check("refill_cnd", 32'(bus.fifo_cnd), 32'd2);
    bus.wr_en    = 1'b1;
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.wr_data = 8'(8'h80 + k);
      check("pp_head", 32'(bus.rd_data), 32'(k));
      step();
      check("pp_level", 32'(bus.level),    32'd512);
      check("pp_cnd",   32'(bus.fifo_cnd), 32'd2);
    end
    bus.wr_en    = 1'b0;
    bus.rd_ready = 1'b0;
    expect_blocks(10, 511);
    for (int k = 0; k < 10; k++) exp_q.push_back({1'b0, 8'(8'h80 + k)});
    drain();
    check("pp_drained_cnd", 32'(bus.fifo_cnd), 32'd0);

    // Streaming through an empty FIFO
    bus.wr_en    = 1'b1;
    bus.rd_ready = 1'b1;
    bus.wr_data  = 8'h10;
    check("stream_first_valid", 32'(bus.rd_valid), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      bus.wr_data = 8'(8'h10 + k - 1);
      step();
      check("stream_valid", 32'(bus.rd_valid), 32'd1);
      check("stream_data",  32'(bus.rd_data),  32'(8'h10 + k - 1));
      check("stream_level", 32'(bus.level),    32'd1);
    end
    bus.wr_en = 1'b0;
    step();
    bus.rd_ready = 1'b0;
    check("stream_end_level", 32'(bus.level), 32'd0);

    // Flush wins over a same-cycle write and restarts the block count
    push_bytes(5, 8'h30);
    check("pre_flush_level", 32'(bus.level), 32'd5);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    step();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    check("flushwr_level", 32'(bus.level),    32'd0);
    check("flushwr_valid", 32'(bus.rd_valid), 32'd0);
    push_bytes(256, 0);
    expect_blocks(0, 255);
    drain();

    // Asynchronous reset in the middle of a block
    for (int i = 0; i < 300; i++) begin
      bus.wr_data = 8'(i);
      bus.wr_en   = 1'b1;
      step();
    end
    check("midburst_cnd", 32'(bus.fifo_cnd), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    bus.wr_en = 1'b0;
    check("async_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("async_rst_level", 32'(bus.level),    32'd0);
    check("async_rst_cnd",   32'(bus.fifo_cnd), 32'd0);
    step();
    rst = 1'b1;
    step();
    push_bytes(256, 0);
    expect_blocks(0, 255);
    drain();
    check("final_level", 32'(bus.level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/trivium_out_fifo.md
# trivium_out_fifo

Output buffer directly downstream of the Trivium encryptor. It accepts ciphertext bytes on the encryptor's `stream`/`wt_sgn` strobe and stores them in a first-word-fall-through FIFO. It drains them to the consumer over a valid/ready handshake and tags the last byte of each block. It also returns the 2-bit `fifo_cnd` status that the encryptor polls before it starts the next block.

## Interface
- `DEPTH`, default 512: FIFO entries; power of two, `DEPTH >= BLOCK`.
- `BLOCK`, default 256: bytes per encryptor block; power of two.
- `clk`, input, 1: clock, all logic on rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `wr_data`, input, 8: ciphertext byte (encryptor `stream`).
- `wr_en`, input, 1: write strobe (encryptor `wt_sgn`); one byte per cycle while high.
- `flush`, input, 1: synchronous clear of contents, block counter and overflow flag.
- `rd_data`, output, 8: head byte, valid when `rd_valid`.
- `rd_last`, output, 1: head byte is byte BLOCK-1 of its block.
- `rd_valid`, output, 1: FIFO non-empty.
- `rd_ready`, input, 1: consumer accepts head byte.
- `fifo_cnd`, output, 2: status to encryptor (encoding below).
- `level`, output, log2(DEPTH)+1: stored entry count, 0..DEPTH.

## Operation
- Storage is a flop array of DEPTH x 9 bits (data plus last tag). It uses wr_ptr/rd_ptr of log2(DEPTH) bits that wrap naturally, plus a separate count register.
- Push condition: `wr_en && (count < DEPTH || pop)`. A push writes `{tag, wr_data}` at wr_ptr, then wr_ptr+1.
- Write-side block counter `blk_cnt`, log2(BLOCK) bits:
  - It increments on every accepted push and wraps at BLOCK.
  - tag = (blk_cnt == BLOCK-1).
  - Dropped writes do not advance it.
- Pop condition: `rd_valid && rd_ready`. A pop does rd_ptr+1.
- `rd_data`/`rd_last` come combinationally from `mem[rd_ptr]`. `rd_valid = (count != 0)`.
- Count update: push only gives +1, pop only gives −1, both or neither leaves it unchanged. `level = count`.
- Full with `wr_en` and no pop:
  - The byte is dropped and pointers and count are unchanged.
  - The sticky flag `ovf` is set.
- Full with `wr_en` and a pop in the same cycle: the push is accepted and the count stays DEPTH.
- Empty with `wr_en` and `rd_ready`: the push is accepted and no pop occurs, because `rd_valid` = 0.
- `fifo_cnd` is combinational from registered state, in priority order:
  - 2'b11: `ovf` set.
  - 2'b10: count == DEPTH.
  - 2'b01: 0 < DEPTH−count < BLOCK.
  - 2'b00: DEPTH−count >= BLOCK, meaning room for a full block. The encryptor resumes only on 00.
- `ovf` is cleared only by `flush` or reset.
- `flush` has priority over a same-cycle push and pop. The push is discarded. Pointers, count, blk_cnt and ovf all go to 0. Memory contents need not be cleared.

## Timing
- Reset (async, `rst` low) takes pointers, count, blk_cnt and ovf to 0. Outputs: `rd_valid`=0, `level`=0, `fifo_cnd`=2'b00. `rd_data`/`rd_last` are don't-care while `rd_valid`=0; memory is not reset.
- Write-to-read latency is 1 cycle. A byte pushed at edge N appears at the head with `rd_valid`=1 after edge N, if the FIFO was empty.
- `fifo_cnd` and `level` reflect a push or pop at edge N immediately after edge N.
  - The encryptor samples `fifo_cnd` one cycle late, so the FIFO must be able to absorb a block in flight.
  - The 00 threshold guarantees this, because the encryptor checks only between blocks.
- The FIFO sustains 1 push and 1 pop per cycle with no bubbles.
- Reset mid-block discards all data. The next accepted byte starts a new block at blk_cnt 0.

## Test plan
- Reset, then idle: `rd_valid`=0, `level`=0, `fifo_cnd`=00. Assert `rst` low mid-burst: all of these return immediately, asynchronously.
- Push 256 bytes 0x00..0xFF with `rd_ready`=0 (DEPTH 512): `level`=256, `fifo_cnd`=00. Push 1 more: `level`=257, `fifo_cnd`=01.
- Continue to 512 entries: `fifo_cnd`=10. Push 0xAA with no pop: dropped, `level`=512, `fifo_cnd`=11. Drain all: `fifo_cnd` stays 11 and the data contains no 0xAA. Pulse `flush`: `fifo_cnd`=00.
- Drain after pushing 0x00..0xFF twice: bytes arrive in order, and `rd_last`=1 only on the two 0xFF bytes (entries 255 and 511).
- At full, hold `wr_en`=1 and `rd_ready`=1 for 10 cycles: all 10 bytes are accepted, `level` stays 512, no overflow, and order is preserved.
- Empty FIFO with `wr_en`=1 and `rd_ready`=1 continuously: first `rd_valid` is 1 cycle after the first write, then one byte per cycle. Also `flush` together with `wr_en`: `level`=0 the next cycle.
